clap_command_sequencer: RTL and testbench

//  Sits downstream of the microphone clap detector. Groups clap pulses into 1..MAX_CLAPS bursts,

---
 rtl/clap_command_sequencer_if.sv | 26 ++
 rtl/clap_command_sequencer.sv | 147 ++++++++++++++
 tb/tb_clap_command_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clap_command_sequencer_if.sv
// Clap sequencer bundle: enable/clap/ready into the sequencer; command, toggle flags and status out.
// master = sequencer side, slave = environment side.
interface clap_command_sequencer_if #(
  parameter int MAX_CLAPS = 3
);
  localparam int CW = $clog2(MAX_CLAPS + 1);

  logic                 enable_i;
  logic                 clap_i;
  logic                 cmd_valid_o;
  logic [CW-1:0]        cmd_o;
  logic                 cmd_ready_i;
  logic [MAX_CLAPS-1:0] toggle_o;
  logic                 drop_o;
  logic                 busy_o;

  modport master (
    input  enable_i, clap_i, cmd_ready_i,
    output cmd_valid_o, cmd_o, toggle_o, drop_o, busy_o
  );

  modport slave (
    output enable_i, clap_i, cmd_ready_i,
    input  cmd_valid_o, cmd_o, toggle_o, drop_o, busy_o
  );
endinterface

// File: rtl/clap_command_sequencer.sv
// Groups synchronized clap edges into 1..MAX_CLAPS bursts and issues one count command per burst.
// Command valid GAP_MAX cycles after the last clap (next edge on reaching MAX_CLAPS); held until ready; all outputs registered.
module clap_command_sequencer #(
  parameter int GAP_MIN   = 2_000_000,
  parameter int GAP_MAX   = 50_000_000,
  parameter int MAX_CLAPS = 3,
  parameter int LOCKOUT   = 30_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  clap_command_sequencer_if.master bus
);
  localparam int CW = $clog2(MAX_CLAPS + 1);
  localparam int TW = $clog2(GAP_MAX + 1);
  localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  localparam logic [TW-1:0]        GAP_MIN_T = TW'(GAP_MIN);
  localparam logic [TW-1:0]        GAP_LAST  = TW'(GAP_MAX - 1);
  localparam logic [TW-1:0]        TIMER_SAT = TW'(GAP_MAX);
  localparam logic [LW-1:0]        LOCK_LAST = LW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
  localparam logic [CW-1:0]        CNT_MAX   = CW'(MAX_CLAPS);
  localparam logic [MAX_CLAPS-1:0] TOG_ONE   = MAX_CLAPS'(1);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD, LOCK} state_t;

  state_t               state;
  logic                 s1, s2, s3;
  logic [TW-1:0]        timer;
  logic [LW-1:0]        lock_cnt;
  logic [CW-1:0]        cnt;
  logic                 cmd_valid_q;
  logic [CW-1:0]        cmd_q;
  logic [MAX_CLAPS-1:0] toggle_q;
  logic                 drop_q;
  logic                 busy_q;

  logic                 evt;
  logic [CW-1:0]        cnt_inc;

  // s1/s2 resolve metastability; s3 only provides the previous sample for edge detection
  assign evt     = s2 & ~s3;
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      timer       <= '0;
      lock_cnt    <= '0;
      cnt         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      toggle_q    <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1     <= bus.clap_i;
      s2     <= s1;
      s3     <= s2;
      drop_q <= 1'b0;

      case (state)
        IDLE: begin
          if (evt && bus.enable_i) begin
            cnt    <= CW'(1);
            timer  <= '0;
            busy_q <= 1'b1;
            if (MAX_CLAPS == 1) begin
              state       <= HOLD;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CW'(1);
            end else begin
              state <= COUNT;
            end
          end
        end

        COUNT: begin
          if (!bus.enable_i) begin
            state  <= IDLE;
            cnt    <= '0;
            timer  <= '0;
            busy_q <= 1'b0;
          end else if (evt && (timer >= GAP_MIN_T)) begin
            // an accepted clap on the timeout edge still extends the burst
            cnt   <= cnt_inc;
            timer <= '0;
            if (cnt_inc == CNT_MAX) begin
              state       <= HOLD;
              cmd_valid_q <= 1'b1;
              cmd_q       <= cnt_inc;
            end
          end else if (timer == GAP_LAST) begin
            state       <= HOLD;
            cmd_valid_q <= 1'b1;
            cmd_q       <= cnt;
          end else if (timer != TIMER_SAT) begin
            timer <= timer + TW'(1);
          end
        end

        HOLD: begin
          if (evt) begin
            drop_q <= 1'b1;
          end
          if (bus.cmd_ready_i) begin
            toggle_q    <= toggle_q ^ (TOG_ONE << (cnt - CW'(1)));
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cnt         <= '0;
            lock_cnt    <= '0;
            if (LOCKOUT == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= LOCK;
            end
          end
        end

        LOCK: begin
          if (evt) begin
            drop_q <= 1'b1;
          end
          if (lock_cnt == LOCK_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.toggle_o    = toggle_q;
  assign bus.drop_o      = drop_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_clap_command_sequencer.sv
// Randomized burst scenarios planned on an absolute cycle timeline; expected commands, drops and
// busy releases are queued when each scenario is issued and checked by an independent monitor.
module tb_clap_command_sequencer;
  localparam int GAP_MIN   = 4;
  localparam int GAP_MAX   = 20;
  localparam int MAX_CLAPS = 3;
  localparam int LOCKOUT   = 10;
  localparam int NPLAN     = 8192;
  localparam int NSCEN     = 30;

  typedef struct {
    int         cmd;
    int         rise;
    int         fall;
    logic [2:0] tog_b;
    logic [2:0] tog_a;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t       cmd_q[$];
  int         drop_q[$];
  int         busy_q[$];
  logic [2:0] tog = 3'b000;

  // Planned input values, indexed by the cycle whose falling edge drives them.
  // A clap consumed by the sequencer at edge t is driven high at the falling edge of cycle t-3.
  bit clap_plan [NPLAN];
  bit rdy_plan  [NPLAN];
  bit en_plan   [NPLAN];

  clap_command_sequencer_if #(.MAX_CLAPS(MAX_CLAPS)) bus ();

  clap_command_sequencer #(
    .GAP_MIN  (GAP_MIN),
    .GAP_MAX  (GAP_MAX),
    .MAX_CLAPS(MAX_CLAPS),
    .LOCKOUT  (LOCKOUT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic drive_until(input int c_end);
    while (cyc < c_end) begin
      @(negedge clk);
      bus.clap_i      = clap_plan[cyc];
      bus.cmd_ready_i = rdy_plan[cyc];
      bus.enable_i    = en_plan[cyc];
    end
  endtask

  // Reference: a burst starts at t1; a later clap k cycles after the last accepted one is
  // accepted for GAP_MIN < k <= GAP_MAX, ignored for k <= GAP_MIN; the burst closes on the
  // MAX_CLAPS-th accepted clap or GAP_MAX cycles after the last accepted one. Claps between
  // the close and the end of lockout are dropped.
  task automatic plan_burst(input int t1, output int t_next);
    int   cnt, last, cur, h, d, e, p, lastclap, ng;
    exp_t x;
    clap_plan[t1-3] = 1'b1;
    cnt = 1;
    last = t1;
    cur = t1;
    ng = $urandom_range(0, 4);
    for (int i = 0; i < ng && cnt < MAX_CLAPS; i++) begin
      int g, tc;
      case ($urandom_range(0, 5))
        0:       g = 2;
        1:       g = GAP_MIN;
        2:       g = GAP_MIN + 1;
        3:       g = GAP_MAX;
        default: g = $urandom_range(2, GAP_MAX);
      endcase
      tc = cur + g;
      if (tc - last > GAP_MAX) break;
      clap_plan[tc-3] = 1'b1;
      cur = tc;
      if (tc - last > GAP_MIN) begin
        cnt++;
        last = tc;
      end
    end
    h = (cnt == MAX_CLAPS) ? last : last + GAP_MAX;
    d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
    e = h + d + 1;
    if (d > 0) begin
      for (int c = t1 - 3; c <= h + d - 1; c++) rdy_plan[c] = 1'b0;
    end
    lastclap = cur;
    p = (h + 1 > cur + 2) ? h + 1 : cur + 2;
    for (int i = 0; i < 3; i++) begin
      p += $urandom_range(0, 5);
      if (p > e + LOCKOUT) break;
      clap_plan[p-3] = 1'b1;
      drop_q.push_back(p);
      lastclap = p;
      p += 2;
    end
    x.cmd   = cnt;
    x.rise  = h;
    x.fall  = e;
    x.tog_b = tog;
    x.tog_a = tog ^ (3'b001 << (cnt - 1));
    tog = x.tog_a;
    cmd_q.push_back(x);
    busy_q.push_back(e + LOCKOUT);
    t_next = e + LOCKOUT + 1 + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8));
    if (t_next < lastclap + 2) t_next = lastclap + 2;
  endtask

  initial begin : monitor
    logic pv, pb, have;
    exp_t cur;
    pv = 1'b0;
    pb = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pv = 1'b0;
        pb = 1'b0;
        have = 1'b0;
        continue;
      end
      if (bus.cmd_valid_o && !pv) begin
        if (cmd_q.size() == 0) begin
          unexpected("cmd_valid");
        end else begin
          cur = cmd_q.pop_front();
          have = 1'b1;
          chk("cmd_value", 32'(bus.cmd_o), cur.cmd);
          chk("cmd_rise_cycle", cyc, cur.rise);
          chk("toggle_before", 32'(bus.toggle_o), 32'(cur.tog_b));
        end
      end else if (bus.cmd_valid_o && have) begin
        chk("cmd_stable", 32'(bus.cmd_o), cur.cmd);
      end
      if (!bus.cmd_valid_o && pv && have) begin
        chk("cmd_fall_cycle", cyc, cur.fall);
        chk("toggle_after", 32'(bus.toggle_o), 32'(cur.tog_a));
        chk("cmd_zero_idle", 32'(bus.cmd_o), 0);
        have = 1'b0;
      end
      if (bus.drop_o) begin
        if (drop_q.size() == 0) unexpected("drop");
        else chk("drop_cycle", cyc, drop_q.pop_front());
      end
      if (!bus.busy_o && pb) begin
        if (busy_q.size() == 0) unexpected("busy_fall");
        else chk("busy_fall_cycle", cyc, busy_q.pop_front());
      end
      pv = bus.cmd_valid_o;
      pb = bus.busy_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete within 50000 cycles");
    $fatal(1);
  end

  initial begin : stim
    int t, tn, ta, tr;
    for (int i = 0; i < NPLAN; i++) begin
      clap_plan[i] = 1'b0;
      rdy_plan[i]  = 1'b1;
      en_plan[i]   = 1'b1;
    end
    bus.clap_i      = 1'b0;
    bus.cmd_ready_i = 1'b1;
    bus.enable_i    = 1'b1;

    #3;
    chk("reset_valid",  32'(bus.cmd_valid_o), 0);
    chk("reset_cmd",    32'(bus.cmd_o), 0);
    chk("reset_toggle", 32'(bus.toggle_o), 0);
    chk("reset_drop",   32'(bus.drop_o), 0);
    chk("reset_busy",   32'(bus.busy_o), 0);
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;

    t = 30;
    for (int s = 0; s < NSCEN; s++) begin
      plan_burst(t, tn);
      drive_until(tn - 6);
      t = tn;
    end

    // Disable mid-burst: two accepted claps, then enable low for one edge aborts silently.
    ta = t;
    clap_plan[ta-3]   = 1'b1;
    clap_plan[ta+5]   = 1'b1;
    en_plan[ta+12]    = 1'b0;
    busy_q.push_back(ta + 13);
    drive_until(ta + 45);

    // Reset mid-burst with two accepted claps: outputs clear at once, nothing follows.
    tr = ta + 50;
    clap_plan[tr-3] = 1'b1;
    clap_plan[tr+5] = 1'b1;
    drive_until(tr + 11);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy_o), 0);
    chk("arst_valid",  32'(bus.cmd_valid_o), 0);
    chk("arst_cmd",    32'(bus.cmd_o), 0);
    chk("arst_toggle", 32'(bus.toggle_o), 0);
    chk("arst_drop",   32'(bus.drop_o), 0);
    tog = 3'b000;
    @(posedge clk);
    #2 rst_ni = 1'b1;

    plan_burst(tr + 60, tn);
    drive_until(tn + 5);

    chk("pending_cmds",  cmd_q.size(), 0);
    chk("pending_drops", drop_q.size(), 0);
    chk("pending_busy",  busy_q.size(), 0);
    chk("final_toggle",  32'(bus.toggle_o), 32'(tog));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
